// File: rtl/stack_pkg.sv
// Shared encodings for the data-stack sequencer: primitive opcodes, FSM
// states, and the per-primitive minimum-depth / growth table.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_DROP    = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_OVER    = 3'd5,
        OP_ROT     = 3'd6,
        OP_REPLACE = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_ROTATE = 2'd2
    } state_e;

    // Entries that must already be on the stack for the primitive to run.
    function automatic logic [1:0] op_min_depth(input op_e op);
        logic [1:0] r_min;
        case (op)
            OP_DROP, OP_DUP, OP_REPLACE: r_min = 2'd1;
            OP_SWAP, OP_OVER:            r_min = 2'd2;
            OP_ROT:                      r_min = 2'd3;
            default:                     r_min = 2'd0;
        endcase
        return r_min;
    endfunction

    // Primitives that add one entry (and therefore can overflow).
    function automatic logic op_grows(input op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Request/response bundle between decode/ALU and the stack sequencer.
// Handshake: a request transfers on a rising clock edge where i_valid and
// o_ready are both high; the requester holds i_op/i_data stable while
// i_valid is high, and o_ready is high exactly when the sequencer is idle.
interface stack_controller_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 20
);
    import stack_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);

    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] o_tos;
    logic [WIDTH-1:0] o_nos;
    logic [DW-1:0]    o_depth;
    logic             o_overflow;
    logic             o_underflow;
    state_e           o_state;

    modport master (
        output i_valid, i_op, i_data,
        input  o_ready, o_tos, o_nos, o_depth, o_overflow, o_underflow, o_state
    );

    modport slave (
        input  i_valid, i_op, i_data,
        output o_ready, o_tos, o_nos, o_depth, o_overflow, o_underflow, o_state
    );

endinterface

// File: rtl/stack_ram.sv
// Single-port spill RAM for stack entries below NOS: synchronous write,
// registered read data one cycle after the address is presented.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int WORDS = 18,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [WORDS];
    logic [WIDTH-1:0] r_rdata;

    // One access per cycle: write when enabled, otherwise register a read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_controller.sv
// Data-stack sequencer: TOS/NOS cached in registers, deeper entries spilled
// to stack_ram. DROP from depth>=3 and ROT need a RAM read and take two
// cycles; everything else completes in the accept cycle.
module stack_controller
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    stack_controller_if.slave bus
);

    localparam int DW        = $clog2(DEPTH + 1);
    localparam int RAM_WORDS = DEPTH - 2;
    localparam int AW        = $clog2(RAM_WORDS);

    state_e           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_tos,    w_tos_nxt;
    logic [WIDTH-1:0] r_nos,    w_nos_nxt;
    logic [DW-1:0]    r_depth,  w_depth_nxt;
    logic             r_ovf,    w_ovf_nxt;
    logic             r_unf,    w_unf_nxt;

    op_e              w_op;
    logic             w_accept;
    logic             w_min_ok;
    logic             w_full;
    logic             w_grow;
    logic [DW-1:0]    w_depth_m2;
    logic [DW-1:0]    w_depth_m3;
    logic [WIDTH-1:0] w_push_val;

    logic             w_ram_we;
    logic [AW-1:0]    w_ram_addr;
    logic [WIDTH-1:0] w_ram_wdata;
    logic [WIDTH-1:0] w_ram_rdata;

    assign w_op       = op_e'(bus.i_op);
    assign w_accept   = bus.i_valid && (r_state == S_IDLE);
    assign w_min_ok   = (r_depth >= DW'(op_min_depth(w_op)));
    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_grow     = op_grows(w_op);
    assign w_depth_m2 = r_depth - DW'(2);
    assign w_depth_m3 = r_depth - DW'(3);

    stack_ram #(
        .WIDTH (WIDTH),
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Value that PUSH / DUP / OVER place on top.
    always_comb begin
        w_push_val = bus.i_data;
        case (w_op)
            OP_DUP:  w_push_val = r_tos;
            OP_OVER: w_push_val = r_nos;
            default: w_push_val = bus.i_data;
        endcase
    end

    // Next-state, register updates, error flags and RAM access per cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tos_nxt   = r_tos;
        w_nos_nxt   = r_nos;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_ram_we    = 1'b0;
        w_ram_addr  = AW'(w_depth_m3);
        w_ram_wdata = r_nos;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_min_ok) begin
                        // Too few entries: flag and discard.
                        w_unf_nxt = 1'b1;
                    end else if (w_grow && w_full) begin
                        // No room for another entry: flag and discard.
                        w_ovf_nxt = 1'b1;
                    end else begin
                        case (w_op)
                            OP_PUSH, OP_DUP, OP_OVER: begin
                                if (r_depth >= DW'(2)) begin
                                    w_ram_we   = 1'b1;
                                    w_ram_addr = AW'(w_depth_m2);
                                end
                                w_nos_nxt   = r_tos;
                                w_tos_nxt   = w_push_val;
                                w_depth_nxt = r_depth + DW'(1);
                            end
                            OP_DROP: begin
                                w_depth_nxt = r_depth - DW'(1);
                                if (r_depth == DW'(1)) begin
                                    w_tos_nxt = '0;
                                end else if (r_depth == DW'(2)) begin
                                    w_tos_nxt = r_nos;
                                    w_nos_nxt = '0;
                                end else begin
                                    // NOS is refilled from RAM next cycle.
                                    w_tos_nxt   = r_nos;
                                    w_state_nxt = S_FILL;
                                end
                            end
                            OP_SWAP: begin
                                w_tos_nxt = r_nos;
                                w_nos_nxt = r_tos;
                            end
                            OP_ROT: begin
                                // Fetch the third entry; rotation completes next cycle.
                                w_state_nxt = S_ROTATE;
                            end
                            OP_REPLACE: begin
                                w_tos_nxt = bus.i_data;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_FILL: begin
                w_nos_nxt   = w_ram_rdata;
                w_state_nxt = S_IDLE;
            end
            S_ROTATE: begin
                // ( a b c -- b c a ): b goes down to a's RAM slot.
                w_ram_we    = 1'b1;
                w_ram_wdata = r_nos;
                w_nos_nxt   = r_tos;
                w_tos_nxt   = w_ram_rdata;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and cached-register update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_tos   <= '0;
            r_nos   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tos   <= w_tos_nxt;
            r_nos   <= w_nos_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign bus.o_ready     = (r_state == S_IDLE);
    assign bus.o_tos       = r_tos;
    assign bus.o_nos       = r_nos;
    assign bus.o_depth     = r_depth;
    assign bus.o_overflow  = r_ovf;
    assign bus.o_underflow = r_unf;
    assign bus.o_state     = r_state;

endmodule

// File: tb/tb_stack_controller.sv
// Directed + short random bench for stack_controller. A behavioural stack
// (plain queue) predicts each result; predictions are queued when a request
// is driven and checked once the controller is ready again.
module tb_stack_controller;
    import stack_pkg::*;

    localparam int W  = 16;
    localparam int D  = 20;
    localparam int EW = 1 + 1 + 5 + W + W;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;

    stack_controller_if #(.WIDTH(W), .DEPTH(D)) bus ();

    stack_controller #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    logic [W-1:0]  m[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        m.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [EW-1:0] model_snapshot();
        int sz;
        logic [W-1:0] t, n;
        sz = m.size();
        t = (sz >= 1) ? m[sz-1] : '0;
        n = (sz >= 2) ? m[sz-2] : '0;
        return {m_ovf, m_unf, 5'(sz), n, t};
    endfunction

    // Predict, drive one request for one cycle, wait for ready, then check.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] d, input string tag);
        int sz, need, lat, cnt;
        bit grow;
        logic [W-1:0] a;
        logic [EW-1:0] e;
        sz = m.size();
        lat = 0;
        case (op)
            3'd2, 3'd3, 3'd7: need = 1;
            3'd4, 3'd5:       need = 2;
            3'd6:             need = 3;
            default:          need = 0;
        endcase
        grow = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
        if (sz < need) begin
            m_unf = 1'b1;
        end else if (grow && sz == D) begin
            m_ovf = 1'b1;
        end else begin
            case (op)
                3'd1: m.push_back(d);
                3'd2: begin
                    void'(m.pop_back());
                    if (sz >= 3) lat = 1;
                end
                3'd3: m.push_back(m[sz-1]);
                3'd4: begin
                    a = m[sz-1];
                    m[sz-1] = m[sz-2];
                    m[sz-2] = a;
                end
                3'd5: m.push_back(m[sz-2]);
                3'd6: begin
                    a = m[sz-3];
                    m.delete(sz-3);
                    m.push_back(a);
                    lat = 1;
                end
                3'd7: m[sz-1] = d;
                default: ;
            endcase
        end
        exp_q.push_back(model_snapshot());
        lat_q.push_back(lat);

        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_data  = d;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        cnt = 0;
        while (!bus.o_ready && cnt < 8) begin
            @(negedge i_clk);
            cnt++;
        end

        e = exp_q.pop_front();
        check({tag, " busy"}, 32'(cnt), 32'(lat_q.pop_front()));
        check({tag, " tos"}, 32'(bus.o_tos), 32'(e[W-1:0]));
        check({tag, " nos"}, 32'(bus.o_nos), 32'(e[2*W-1:W]));
        check({tag, " depth"}, 32'(bus.o_depth), 32'(e[2*W+4:2*W]));
        check({tag, " unf"}, 32'(bus.o_underflow), 32'(e[2*W+5]));
        check({tag, " ovf"}, 32'(bus.o_overflow), 32'(e[2*W+6]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_op    = 3'd0;
        bus.i_data  = '0;

        // Reset state.
        do_reset();
        check("rst tos", 32'(bus.o_tos), 32'h0);
        check("rst nos", 32'(bus.o_nos), 32'h0);
        check("rst depth", 32'(bus.o_depth), 32'h0);
        check("rst flags", 32'({bus.o_overflow, bus.o_underflow}), 32'h0);
        check("rst ready", 32'(bus.o_ready), 32'h1);

        // Three pushes spill the first one to RAM.
        do_op(3'd1, 16'h0011, "push11");
        do_op(3'd1, 16'h0022, "push22");
        do_op(3'd1, 16'h0033, "push33");
        check("ram0 after push", 32'(dut.u_ram.r_mem[0]), 32'h0011);

        // ROT at depth 3.
        do_op(3'd6, 16'h0000, "rot3");
        check("ram0 after rot", 32'(dut.u_ram.r_mem[0]), 32'h0022);

        // Drain and underflow.
        do_op(3'd2, 16'h0000, "drop_a");
        do_op(3'd2, 16'h0000, "drop_b");
        do_op(3'd2, 16'h0000, "drop_c");
        do_op(3'd2, 16'h0000, "drop_unf");

        // Fill to capacity, overflow, then drain in order.
        do_reset();
        for (int i = 1; i <= D; i++) do_op(3'd1, 16'(i), "fill");
        do_op(3'd1, 16'hFFFF, "push_ovf");
        for (int i = 0; i < D; i++) do_op(3'd2, 16'h0000, "drain");

        // Depth-1 boundary behaviour.
        do_reset();
        do_op(3'd1, 16'h0005, "push5");
        do_op(3'd4, 16'h0000, "swap_unf");
        do_op(3'd6, 16'h0000, "rot_unf");
        do_op(3'd3, 16'h0000, "dup");
        do_op(3'd5, 16'h0000, "over");
        do_op(3'd7, 16'h00AA, "replace");
        do_op(3'd0, 16'h1234, "nop");
        do_op(3'd4, 16'h0000, "swap");
        do_op(3'd6, 16'h0000, "rot");

        // Idle cycles change nothing.
        repeat (3) @(negedge i_clk);
        check("idle tos", 32'(bus.o_tos), 32'(m[m.size()-1]));
        check("idle depth", 32'(bus.o_depth), 32'(m.size()));

        // Reset during the FILL cycle of a DROP at depth 5.
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(3'd1, 16'(i * 3), "pre");
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd2;
        bus.i_data  = '0;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        check("fill ready low", 32'(bus.o_ready), 32'h0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        m.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check("midrst ready", 32'(bus.o_ready), 32'h1);
        check("midrst depth", 32'(bus.o_depth), 32'h0);
        check("midrst tos", 32'(bus.o_tos), 32'h0);
        check("midrst flags", 32'({bus.o_overflow, bus.o_underflow}), 32'h0);
        do_op(3'd1, 16'h0007, "push7");

        // Random mix.
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom_range(0, 16'hFFFF)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
Sequencer for the CPU data stack. It caches top-of-stack (TOS) and next-on-stack (NOS) in registers and spills deeper entries to a single-port synchronous stack RAM. It executes one stack primitive per accepted request over a valid/ready handshake, and maintains depth and sticky overflow/underflow flags. It sits between instruction decode/ALU and stack storage; o_tos/o_nos feed the ALU operand paths.

Parameters:
WIDTH, 16, data word width
DEPTH, 20, total stack capacity in entries (TOS + NOS + DEPTH-2 RAM words)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  request strobe
o_ready  out  1  controller can accept a request this cycle
i_op  in  3  primitive: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ROT, 7 REPLACE
i_data  in  WIDTH  operand for PUSH/REPLACE
o_tos  out  WIDTH  top of stack
o_nos  out  WIDTH  second entry
o_depth  out  $clog2(DEPTH+1)  entries currently held
o_overflow  out  1  sticky, set on push past DEPTH
o_underflow  out  1  sticky, set on op needing more entries than present

Behaviour:
- Reset (any state, mid-op included): state IDLE; o_tos=0, o_nos=0, o_depth=0, o_overflow=0, o_underflow=0, o_ready=1. RAM contents not cleared.
- Accept = i_valid & o_ready. o_ready = (state==IDLE).
- RAM: single port, registered read data (1-cycle latency), one access per cycle. Top RAM word at index depth-3 once depth>=3.
- Min depth required / depth change: NOP 0/0; PUSH 0/+1; DROP 1/-1; DUP 1/+1; SWAP 2/0; OVER 2/+1; ROT 3/0; REPLACE 1/0.
- Error rule: when depth < min, set o_underflow. When op grows the stack and depth==DEPTH, set o_overflow. In both cases the op is discarded: no state, register or RAM change, stays IDLE, 1-cycle.
- PUSH (value v) / DUP (v=TOS) / OVER (v=NOS), single cycle, o_ready stays 1:
  - if depth>=2, write NOS to RAM[depth-2];
  - NOS<=TOS, TOS<=v, depth+1.
- SWAP: TOS<->NOS, single cycle.
- REPLACE: TOS<=i_data, single cycle.
- DROP:
  - depth==1: TOS<=0, depth 0, single cycle.
  - depth==2: TOS<=NOS, NOS<=0, depth 1, single cycle.
  - depth>=3: TOS<=NOS, read RAM[depth-3], depth-1, go FILL. In FILL: NOS<=RAM data, back to IDLE. 2 cycles total; o_ready low during FILL.
- ROT ( a b c -- b c a ), where c=TOS, b=NOS, a=RAM[depth-3]:
  - Accept cycle: issue read RAM[depth-3], go ROTATE.
  - ROTATE: write RAM[depth-3]<=NOS(b), NOS<=TOS(c), TOS<=RAM data(a), back to IDLE.
  - 2 cycles total.
- Flags clear only on reset. Operations continue normally after an error.
- NOP and i_valid=0: no change.
- Vacated TOS/NOS registers are driven to 0.

Decomposition:
- Package stack_pkg holds: op encodings (OP_NOP..OP_REPLACE), state encoding (S_IDLE, S_FILL, S_ROTATE), and the min-depth/grow table as constants/function.
- One sub-module, stack_ram: parameterized WIDTH x (DEPTH-2), single port, synchronous write, registered read.

Test Plan:
- Reset, then PUSH 0x0011, 0x0022, 0x0033 -> o_tos=0x0033, o_nos=0x0022, o_depth=3; RAM[0]=0x0011; o_ready never drops.
- From that state, ROT -> o_ready low 1 cycle; then o_tos=0x0011, o_nos=0x0033, RAM[0]=0x0022, depth 3.
- DROP three times from depth 3 -> first DROP takes 2 cycles (NOS refilled from RAM); final o_depth=0, o_tos=0, o_nos=0; a fourth DROP sets o_underflow=1, depth stays 0.
- PUSH 20 values 1..20, then PUSH 0xFFFF -> o_overflow=1, o_tos=20, o_depth=20. DROP chain then returns 19..1 in order.
- Depth 1 (TOS=5): SWAP and ROT each set o_underflow, TOS stays 5. DUP -> tos=nos=5. OVER -> tos=5, depth 3. REPLACE 0x00AA -> tos=0x00AA.
- Assert i_reset in the FILL cycle of a DROP at depth 5 -> next cycle state IDLE, depth 0, flags 0, o_ready=1; a subsequent PUSH 0x0007 gives tos=0x0007, depth 1.
